vdp_cpu_port: RTL
=================

// Module: vdp_cpu_port
// PURPOSE
//  CPU-side front end of the TMS9918-style VDP. Decodes I/O ports 0x98 (data) and 0x99 (control/status).
//  Runs the two-byte control latch, the VDP register file R0-R7 and the auto-incrementing 14-bit VRAM pointer.
//  Drives single-cycle VRAM write/read requests into the video block and generates the frame interrupt from its vblank pulse.
// PARAMETERS
//  DATA_PORT   8'h98  I/O address of VRAM data port
//  CTRL_PORT   8'h99  I/O address of control (write) / status (read) port
//  RD_LATENCY  1      clk cycles from vram_re to valid vram_rdata (1..3)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  reset_n      in   1   asynchronous active-low reset
//  io_en        in   1   CPU clock-enable strobe; bus inputs sampled only when high
//  iorq_n       in   1   Z80 IORQ
//  rd_n         in   1   Z80 RD
//  wr_n         in   1   Z80 WR
//  addr         in   8   Z80 A[7:0]
//  din          in   8   CPU write data
//  dout         out  8   CPU read data; valid while dout_oe
//  dout_oe      out  1   high while a read of DATA_PORT or CTRL_PORT is active
//  vram_addr    out  14  VRAM address for current request
//  vram_wdata   out  8   VRAM write data
//  vram_we      out  1   one-clk VRAM write pulse
//  vram_re      out  1   one-clk VRAM read pulse
//  vram_rdata   in   8   VRAM read data, RD_LATENCY clks after vram_re
//  vblank       in   1   one-clk pulse at start of vertical blank
//  regs         out  64  R7..R0 flattened, R0 in [7:0]
//  int_n        out  1   interrupt to CPU, active low
// BEHAVIOUR
//  Reset: R0-R7=0, vram pointer=0, latch flag=0, read buffer=0, F=0; dout=0, dout_oe=0, vram_we/re=0, int_n=1.
//  Access start: on an io_en cycle where iorq_n=0 and (rd_n=0 or wr_n=0), and the previous io_en sample was inactive;
//   exactly one action per Z80 I/O cycle.
//  Ctrl write, latch flag=0: latch<=din, flag<=1.
//  Ctrl write, flag=1: flag<=0.
//   din[7]=1: R[din[2:0]]<=latch.
//   din[7:6]=00: ptr<={din[5:0],latch}, then prefetch.
//   din[7:6]=01: ptr<={din[5:0],latch}, no prefetch.
//  Prefetch: vram_re pulse at ptr; buffer<=vram_rdata; ptr<=ptr+1.
//  Data write: vram_we pulse with vram_addr=ptr, vram_wdata=din; buffer<=din; ptr<=ptr+1; flag<=0.
//  Data read: dout=buffer (value before this access), then prefetch; flag<=0.
//  Ctrl read: dout={F,7'b0}; at access end F<=0, flag<=0.
//  Pointer wraps 14'h3FFF -> 14'h0000.
//  int_n = ~(F & R1[5]) registered; one clk after F or R1[5] changes.
//  FSM: IDLE -> (data write) WR -> IDLE, 1 clk.
//   IDLE -> (prefetch) RD_WAIT[RD_LATENCY] -> RD_CAP -> IDLE.
//   CPU I/O cycles are longer than RD_CAP+1 clks, so new access never meets non-IDLE state.
//   If one does, it is dropped and the FSM finishes its current request.
//  Simultaneous vblank and status-clear in one clk: set wins, F=1.
//  Reset asserted mid-request: FSM to IDLE at once, no pending pulse later.
//  Port-address mismatch on any access: no state change, dout_oe=0.
// CONFIGURATION
//  VDP_STATUS_EN defined: status read as above; vblank sets F; int_n as above.
//  VDP_STATUS_EN undefined: ctrl read returns 8'h00; F tied 0; int_n constant 1; vblank ignored.
//   Ctrl read still clears latch flag.
// STRUCTURE
//  vdp_defs.vh include: port addresses, FSM state encodings, register indices, STATUS_F_BIT.
//  Sub-module io_access_detect: io_en-qualified start-of-access strobes rd_start/wr_start from iorq_n/rd_n/wr_n.
//  Top of block: latch/register/pointer logic and VRAM FSM.
// TESTING
//  Ctrl writes 0x00,0x41 then data write 0xAB -> vram_we one clk, vram_addr=0x0100, wdata=0xAB; ptr=0x0101.
//  Ctrl writes 0xE0,0x81 -> R1=0xE0 in regs[15:8]; no VRAM pulse.
//  Ctrl writes 0xFF,0x3F (read setup), data read -> vram_re at 0x3FFF; ptr wraps to 0x0000.
//   Read returns the prefetched byte; next vram_re at 0x0000.
//  R1=0x20, vblank pulse -> int_n=0.
//   Ctrl read returns 0x80, then int_n=1.
//   Second ctrl read returns 0x00.
//  vblank coincident with status-clear clk -> F stays 1, int_n stays 0.
//  Single ctrl write 0x12, then data read, then ctrl writes 0x34,0x40 -> ptr=0x0034 (flag was cleared).
//  reset_n low during RD_WAIT -> vram_re stays 0, buffer=0, ptr=0.
//  Rerun with VDP_STATUS_EN off -> ctrl read returns 0x00, int_n constant 1.

Source files
------------

// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU port: default I/O addresses, VRAM request
// FSM encoding, register indices and status bit positions.
package vdp_cpu_port_pkg;

    // Default Z80 I/O addresses of the data and control/status ports
    localparam logic [7:0] DEF_DATA_PORT = 8'h98;
    localparam logic [7:0] DEF_CTRL_PORT = 8'h99;

    // VRAM request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_CAP  = 2'd3
    } vram_state_t;

    // Register file layout
    localparam int NUM_REGS      = 8;
    localparam int REG_MODE1     = 1;
    localparam int MODE1_IE_BIT  = 5;   // frame interrupt enable in R1
    localparam int STATUS_F_BIT  = 7;   // frame flag in the status byte

    // Second control byte command field din[7:6] when din[7]=0
    localparam logic [1:0] CMD_READ_SETUP  = 2'b00;
    localparam logic [1:0] CMD_WRITE_SETUP = 2'b01;

    // Builds the 14-bit VRAM address from the second and first control bytes
    function automatic logic [13:0] setup_addr(input logic [5:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/vdp_cpu_port_io_access_detect.sv
// Start-of-access detector for the Z80 I/O bus. Bus pins are only looked at on
// io_en cycles; a start strobe fires on the first io_en sample of an I/O cycle,
// and access_end fires on the first io_en sample after it finishes.
module io_access_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic io_en,
    input  logic iorq_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic rd_start,
    output logic wr_start,
    output logic access_end
);

    logic active;
    logic prev_active_reg;

    assign active = ~iorq_n & (~rd_n | ~wr_n);

    // Remember whether the previous io_en sample saw an active I/O cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_active_reg <= 1'b0;
        end else if (io_en) begin
            prev_active_reg <= active;
        end
    end

    // Reads take priority if a malformed cycle drives both strobes
    assign rd_start   = io_en & active & ~prev_active_reg & ~rd_n;
    assign wr_start   = io_en & active & ~prev_active_reg & rd_n & ~wr_n;
    assign access_end = io_en & ~active & prev_active_reg;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side front end of a TMS9918-style VDP: control latch, register file R0-R7,
// auto-incrementing 14-bit VRAM pointer, VRAM request sequencer and frame IRQ.
// Optional feature macro: VDP_STATUS_EN (status flag F, vblank handling, int_n).
module vdp_cpu_port
    import vdp_cpu_port_pkg::*;
#(
    parameter logic [7:0] DATA_PORT  = DEF_DATA_PORT,
    parameter logic [7:0] CTRL_PORT  = DEF_CTRL_PORT,
    parameter int         RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_en,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re,
    input  logic [7:0]  vram_rdata,
    input  logic        vblank,
    output logic [63:0] regs,
    output logic        int_n
);

    localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

    logic rd_start, wr_start, access_end;

    io_access_detect u_detect (
        .clk        (clk),
        .reset_n    (reset_n),
        .io_en      (io_en),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .rd_start   (rd_start),
        .wr_start   (wr_start),
        .access_end (access_end)
    );

    vram_state_t state_reg, state_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;

    logic [7:0]  vdp_reg [NUM_REGS];
    logic [7:0]  latch_reg;
    logic        flag_reg;
    logic [13:0] ptr_reg;
    logic [13:0] req_addr_reg;
    logic [7:0]  wdata_reg;
    logic [7:0]  buffer_reg;
    logic [7:0]  dout_reg;
    logic        dout_oe_reg;
    logic        ctrl_rd_pend_reg;
    logic        f_reg;
    logic [7:0]  status_byte;

    // Access decode; anything that needs the sequencer is dropped while it is busy
    logic is_data, is_ctrl, fsm_idle;
    logic data_wr, data_rd, ctrl_wr, ctrl_rd;
    logic ctrl_first, ctrl_second, ctrl_reg_wr, ctrl_set_noprefetch, ctrl_set_prefetch;
    logic start_write, start_prefetch, status_clear;
    logic [13:0] setup_ptr;

    assign is_data   = (addr == DATA_PORT);
    assign is_ctrl   = (addr == CTRL_PORT);
    assign fsm_idle  = (state_reg == ST_IDLE);

    assign data_wr   = wr_start & is_data & fsm_idle;
    assign data_rd   = rd_start & is_data & fsm_idle;
    assign ctrl_wr   = wr_start & is_ctrl;
    assign ctrl_rd   = rd_start & is_ctrl;

    assign ctrl_first          = ctrl_wr & ~flag_reg;
    assign ctrl_second         = ctrl_wr & flag_reg;
    assign ctrl_reg_wr         = ctrl_second & din[7];
    assign ctrl_set_noprefetch = ctrl_second & (din[7:6] == CMD_WRITE_SETUP);
    assign ctrl_set_prefetch   = ctrl_second & (din[7:6] == CMD_READ_SETUP) & fsm_idle;
    assign setup_ptr           = setup_addr(din[5:0], latch_reg);

    assign start_write    = data_wr;
    assign start_prefetch = data_rd | ctrl_set_prefetch;
    assign status_clear   = access_end & ctrl_rd_pend_reg;

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Sequencer next state: WR for one clk, or RD_LATENCY wait clks then capture
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_write) begin
                    state_next = ST_WR;
                end else if (start_prefetch) begin
                    state_next    = ST_RD_WAIT;
                    wait_cnt_next = 2'd0;
                end
            end
            ST_WR:      state_next = ST_IDLE;
            ST_RD_WAIT: begin
                if (wait_cnt_reg == LAST_WAIT) begin
                    state_next = ST_RD_CAP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            ST_RD_CAP:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Sequencer outputs: the read pulse is issued on the first wait clk only
    always_comb begin
        vram_we = 1'b0;
        vram_re = 1'b0;
        case (state_reg)
            ST_WR:      vram_we = 1'b1;
            ST_RD_WAIT: vram_re = (wait_cnt_reg == 2'd0);
            default:    ;
        endcase
    end

    assign vram_addr  = req_addr_reg;
    assign vram_wdata = wdata_reg;

    // Control latch, register file, pointer, read buffer and CPU read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                vdp_reg[i] <= 8'h00;
            end
            latch_reg        <= 8'h00;
            flag_reg         <= 1'b0;
            ptr_reg          <= 14'h0000;
            req_addr_reg     <= 14'h0000;
            wdata_reg        <= 8'h00;
            buffer_reg       <= 8'h00;
            dout_reg         <= 8'h00;
            dout_oe_reg      <= 1'b0;
            ctrl_rd_pend_reg <= 1'b0;
        end else begin
            if (ctrl_first) begin
                latch_reg <= din;
                flag_reg  <= 1'b1;
            end
            if (ctrl_second || data_wr || data_rd || status_clear) begin
                flag_reg <= 1'b0;
            end
            if (ctrl_reg_wr) begin
                vdp_reg[din[2:0]] <= latch_reg;
            end
            if (ctrl_set_noprefetch) begin
                ptr_reg <= setup_ptr;
            end
            if (ctrl_set_prefetch) begin
                req_addr_reg <= setup_ptr;
                ptr_reg      <= setup_ptr + 14'd1;
            end
            if (data_wr || data_rd) begin
                req_addr_reg <= ptr_reg;
                ptr_reg      <= ptr_reg + 14'd1;
            end
            if (data_wr) begin
                wdata_reg  <= din;
                buffer_reg <= din;
            end
            if (state_reg == ST_RD_CAP) begin
                buffer_reg <= vram_rdata;
            end
            if (rd_start && is_data) begin
                dout_reg    <= buffer_reg;
                dout_oe_reg <= 1'b1;
            end
            if (ctrl_rd) begin
                dout_reg         <= status_byte;
                dout_oe_reg      <= 1'b1;
                ctrl_rd_pend_reg <= 1'b1;
            end
            if (access_end) begin
                dout_oe_reg      <= 1'b0;
                ctrl_rd_pend_reg <= 1'b0;
            end
        end
    end

    assign dout    = dout_reg;
    assign dout_oe = dout_oe_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            assign regs[gi*8 +: 8] = vdp_reg[gi];
        end
    endgenerate

`ifdef VDP_STATUS_EN
    logic int_n_reg;

    // Frame flag: vblank sets it, the end of a status read clears it; set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_reg <= 1'b0;
        end else if (vblank) begin
            f_reg <= 1'b1;
        end else if (status_clear) begin
            f_reg <= 1'b0;
        end
    end

    // Registered interrupt output, gated by the R1 interrupt enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_n_reg <= 1'b1;
        end else begin
            int_n_reg <= ~(f_reg & vdp_reg[REG_MODE1][MODE1_IE_BIT]);
        end
    end

    assign int_n = int_n_reg;
`else
    logic unused_vblank;

    assign f_reg         = 1'b0;
    assign int_n         = 1'b1;
    assign unused_vblank = vblank;
`endif

    // Status byte as seen by a control-port read
    always_comb begin
        status_byte               = 8'h00;
        status_byte[STATUS_F_BIT] = f_reg;
    end

endmodule
